// File: rtl/udp_header_filter_pkg.sv
// Shared types, byte offsets and the reason priority encoder for the UDP header filter.
package udp_filter_pkg;

  typedef enum logic [2:0] {
    RSN_PASS  = 3'd0,
    RSN_MAC   = 3'd1,
    RSN_ETYPE = 3'd2,
    RSN_IPHDR = 3'd3,
    RSN_PROTO = 3'd4,
    RSN_IP    = 3'd5,
    RSN_PORT  = 3'd6,
    RSN_RUNT  = 3'd7
  } reason_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_BODY    = 2'd2,
    S_VERDICT = 2'd3
  } state_t;

  localparam int IDX_W = 6;

  localparam logic [IDX_W-1:0] OFF_DA    = 6'd0;
  localparam logic [IDX_W-1:0] OFF_ETYPE = 6'd12;
  localparam logic [IDX_W-1:0] OFF_VIHL  = 6'd14;
  localparam logic [IDX_W-1:0] OFF_PROTO = 6'd23;
  localparam logic [IDX_W-1:0] OFF_DIP   = 6'd30;
  localparam logic [IDX_W-1:0] OFF_DPORT = 6'd36;
  localparam logic [IDX_W-1:0] HDR_LAST  = 6'd37;
  localparam logic [IDX_W-1:0] IDX_MAX   = 6'd63;

  localparam logic [7:0] VIHL_IPV4 = 8'h45;

  // Flag bit positions follow byte order, so the lowest set bit is the first failure.
  localparam int CHK_MAC   = 0;
  localparam int CHK_ETYPE = 1;
  localparam int CHK_IPHDR = 2;
  localparam int CHK_PROTO = 3;
  localparam int CHK_IP    = 4;
  localparam int CHK_PORT  = 5;
  localparam int N_CHK     = 6;

  typedef struct packed {
    logic [47:0] mac;
    logic [15:0] etype;
    logic [7:0]  proto;
    logic [31:0] ip_base;
    logic [31:0] ip_mask;
    logic [15:0] port;
  } cfg_t;

  function automatic reason_t first_fail(input logic [N_CHK-1:0] flags);
    reason_t r;
    r = RSN_PASS;
    if (flags[CHK_MAC])        r = RSN_MAC;
    else if (flags[CHK_ETYPE]) r = RSN_ETYPE;
    else if (flags[CHK_IPHDR]) r = RSN_IPHDR;
    else if (flags[CHK_PROTO]) r = RSN_PROTO;
    else if (flags[CHK_IP])    r = RSN_IP;
    else if (flags[CHK_PORT])  r = RSN_PORT;
    return r;
  endfunction

endpackage

// File: rtl/udp_header_filter_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over a coincident increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/udp_header_filter.sv
// Ethernet/IPv4/UDP header classifier: one pass/drop verdict per byte-streamed frame,
// judged against a config snapshot taken when the frame's first byte is accepted.
module udp_header_filter
  import udp_filter_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [47:0]      local_mac,
  input  logic [15:0]      ethertype,
  input  logic [7:0]       ip_protocol,
  input  logic [31:0]      ip_base,
  input  logic [31:0]      ip_mask,
  input  logic [15:0]      udp_dst_port,
  input  logic             stats_clr,
  output logic             m_verdict_valid,
  input  logic             m_verdict_ready,
  output logic             m_verdict_pass,
  output logic [2:0]       m_verdict_reason,
  output logic [LEN_W-1:0] m_verdict_len,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [LEN_W-1:0] len_q;
  logic [N_CHK-1:0] flags_q;
  cfg_t             cfg_q;
  logic             s_tready_q;
  logic             vld_q;
  logic             pass_q;
  reason_t          reason_q;
  logic [LEN_W-1:0] vlen_q;

  cfg_t             cfg_live;
  cfg_t             cfg_cur;
  logic             in_idle;
  logic             beat;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] idx_d;
  logic [LEN_W-1:0] base_len;
  logic [LEN_W-1:0] len_d;
  logic [N_CHK-1:0] cur_mm;
  logic [N_CHK-1:0] flags_d;
  logic             runt;
  logic             pass_d;
  reason_t          reason_d;

  assign cfg_live = '{mac: local_mac, etype: ethertype, proto: ip_protocol,
                      ip_base: ip_base, ip_mask: ip_mask, port: udp_dst_port};

  // Byte 0 is checked against the live config, which is also what gets snapshotted.
  assign in_idle  = (state_q == S_IDLE);
  assign cfg_cur  = in_idle ? cfg_live : cfg_q;
  assign beat     = s_tvalid & s_tready_q;
  assign cur_idx  = in_idle ? '0 : idx_q;
  assign idx_d    = (cur_idx == IDX_MAX) ? cur_idx : cur_idx + 1'b1;
  assign base_len = in_idle ? '0 : len_q;
  assign len_d    = (&base_len) ? base_len : base_len + 1'b1;

  logic [5:0] mac_mm;
  logic [1:0] etype_mm;
  logic [3:0] dip_mm;
  logic [1:0] dport_mm;
  logic       vihl_mm;
  logic       proto_mm;

  for (genvar gi = 0; gi < 6; gi++) begin : g_mac
    assign mac_mm[gi] = (cur_idx == OFF_DA + 6'(gi)) &&
                        (s_tdata != cfg_cur.mac[47-8*gi -: 8]);
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port_etype
    assign etype_mm[gi] = (cur_idx == OFF_ETYPE + 6'(gi)) &&
                          (s_tdata != cfg_cur.etype[15-8*gi -: 8]);
    assign dport_mm[gi] = (cur_idx == OFF_DPORT + 6'(gi)) &&
                          (s_tdata != cfg_cur.port[15-8*gi -: 8]);
  end

  // Masked range compare done one byte at a time as the address streams in.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dip
    assign dip_mm[gi] = (cur_idx == OFF_DIP + 6'(gi)) &&
                        ((s_tdata & cfg_cur.ip_mask[31-8*gi -: 8]) !=
                         (cfg_cur.ip_base[31-8*gi -: 8] & cfg_cur.ip_mask[31-8*gi -: 8]));
  end

  assign vihl_mm  = (cur_idx == OFF_VIHL)  && (s_tdata != VIHL_IPV4);
  assign proto_mm = (cur_idx == OFF_PROTO) && (s_tdata != cfg_cur.proto);

  always_comb begin
    cur_mm            = '0;
    cur_mm[CHK_MAC]   = |mac_mm;
    cur_mm[CHK_ETYPE] = |etype_mm;
    cur_mm[CHK_IPHDR] = vihl_mm;
    cur_mm[CHK_PROTO] = proto_mm;
    cur_mm[CHK_IP]    = |dip_mm;
    cur_mm[CHK_PORT]  = |dport_mm;
  end

  assign flags_d = (in_idle ? '0 : flags_q) | cur_mm;
  assign runt    = (cur_idx < HDR_LAST);

  always_comb begin
    pass_d   = 1'b0;
    reason_d = RSN_PASS;
    if (flags_d != '0) begin
      reason_d = first_fail(flags_d);
    end else if (runt) begin
      reason_d = RSN_RUNT;
    end else begin
      pass_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      flags_q    <= '0;
      cfg_q      <= '0;
      s_tready_q <= 1'b1;
      vld_q      <= 1'b0;
      pass_q     <= 1'b0;
      reason_q   <= RSN_PASS;
      vlen_q     <= '0;
    end else begin
      if (in_idle) begin
        cfg_q <= cfg_live;
      end
      case (state_q)
        S_IDLE, S_HDR, S_BODY: begin
          if (beat) begin
            idx_q   <= idx_d;
            len_q   <= len_d;
            flags_q <= flags_d;
            if (s_tlast) begin
              state_q    <= S_VERDICT;
              s_tready_q <= 1'b0;
              vld_q      <= 1'b1;
              pass_q     <= pass_d;
              reason_q   <= reason_d;
              vlen_q     <= len_d;
            end else if (state_q == S_IDLE) begin
              state_q <= S_HDR;
            end else if (state_q == S_HDR && cur_idx == HDR_LAST) begin
              state_q <= S_BODY;
            end
          end
        end
        S_VERDICT: begin
          if (m_verdict_ready) begin
            state_q    <= S_IDLE;
            s_tready_q <= 1'b1;
            vld_q      <= 1'b0;
          end
        end
      endcase
    end
  end

  assign s_tready         = s_tready_q;
  assign m_verdict_valid  = vld_q;
  assign m_verdict_pass   = pass_q;
  assign m_verdict_reason = reason_q;
  assign m_verdict_len    = vlen_q;

  logic pass_inc;
  logic drop_inc;
  assign pass_inc = vld_q & m_verdict_ready & pass_q;
  assign drop_inc = vld_q & m_verdict_ready & ~pass_q;

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (stats_clr),
    .inc_i (pass_inc),
    .cnt_o (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (stats_clr),
    .inc_i (drop_inc),
    .cnt_o (drop_cnt)
  );

endmodule

// File: tb/tb_udp_header_filter.sv
// Directed bench for udp_header_filter; narrow counter/length widths expose saturation quickly.
module tb_udp_header_filter;

  localparam int CNT_W = 4;
  localparam int LEN_W = 6;
  localparam int CNT_MAX = 15;
  localparam int LEN_MAX = 63;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic             s_tlast;
  logic [47:0]      local_mac;
  logic [15:0]      ethertype;
  logic [7:0]       ip_protocol;
  logic [31:0]      ip_base;
  logic [31:0]      ip_mask;
  logic [15:0]      udp_dst_port;
  logic             stats_clr;
  logic             m_verdict_valid;
  logic             m_verdict_ready;
  logic             m_verdict_pass;
  logic [2:0]       m_verdict_reason;
  logic [LEN_W-1:0] m_verdict_len;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] drop_cnt;

  udp_header_filter #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .s_tdata          (s_tdata),
    .s_tvalid         (s_tvalid),
    .s_tready         (s_tready),
    .s_tlast          (s_tlast),
    .local_mac        (local_mac),
    .ethertype        (ethertype),
    .ip_protocol      (ip_protocol),
    .ip_base          (ip_base),
    .ip_mask          (ip_mask),
    .udp_dst_port     (udp_dst_port),
    .stats_clr        (stats_clr),
    .m_verdict_valid  (m_verdict_valid),
    .m_verdict_ready  (m_verdict_ready),
    .m_verdict_pass   (m_verdict_pass),
    .m_verdict_reason (m_verdict_reason),
    .m_verdict_len    (m_verdict_len),
    .pass_cnt         (pass_cnt),
    .drop_cnt         (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pass = 0;
  int exp_drop = 0;
  int frame_no = 0;
  logic [7:0] frame [0:127];

  localparam logic [47:0] GOOD_MAC = 48'hCAFE_DEADBEEF;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build(input logic [47:0] da, input logic [15:0] et, input logic [7:0] vihl,
                       input logic [7:0] pr, input logic [31:0] dip, input logic [15:0] dp);
    for (int i = 0; i < 128; i++) frame[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 6; i++) frame[i] = da[47-8*i -: 8];
    frame[12] = et[15:8];
    frame[13] = et[7:0];
    frame[14] = vihl;
    frame[23] = pr;
    for (int i = 0; i < 4; i++) frame[30+i] = dip[31-8*i -: 8];
    frame[36] = dp[15:8];
    frame[37] = dp[7:0];
  endtask

  task automatic build_good();
    build(GOOD_MAC, 16'h0800, 8'h45, 8'h11, 32'h0A000102, 16'h63DD);
  endtask

  // Called at a negedge; returns at the negedge right after the last byte is accepted.
  task automatic send(input int n, input int cfg_at, input int rst_at);
    for (int i = 0; i < n; i++) begin
      s_tdata  = frame[i];
      s_tvalid = 1'b1;
      s_tlast  = (i == n - 1);
      if (i == cfg_at) udp_dst_port = 16'h1234;
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
      begin
        int t;
        t = 0;
        while (!s_tready && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (t == 50) check_val("tready_timeout", 64'(s_tready), 64'd1);
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_verdict(input logic p, input logic [2:0] r, input int l,
                                input int stall, input logic clr);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    frame_no++;
    check_val("verdict_valid", 64'(m_verdict_valid), 64'd1);
    check_val("tready_bubble", 64'(s_tready), 64'd0);
    check_val("verdict_pass", 64'(m_verdict_pass), 64'(p));
    check_val("verdict_reason", 64'(m_verdict_reason), 64'(r));
    check_val("verdict_len", 64'(m_verdict_len), 64'(l));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check_val("stall_valid", 64'(m_verdict_valid), 64'd1);
      check_val("stall_tready", 64'(s_tready), 64'd0);
      check_val("stall_reason", 64'(m_verdict_reason), 64'(r));
      check_val("stall_len", 64'(m_verdict_len), 64'(l));
    end
    m_verdict_ready = 1'b1;
    if (clr) begin
      stats_clr = 1'b1;
      exp_pass  = 0;
      exp_drop  = 0;
    end else if (p) begin
      if (exp_pass < CNT_MAX) exp_pass++;
    end else begin
      if (exp_drop < CNT_MAX) exp_drop++;
    end
    @(negedge clk);
    stats_clr = 1'b0;
    check_val("post_valid", 64'(m_verdict_valid), 64'd0);
    check_val("post_tready", 64'(s_tready), 64'd1);
    check_val("pass_cnt", 64'(pass_cnt), 64'(exp_pass));
    check_val("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    $display("frame %0d: pass=%0d reason=%0d len=%0d pass_cnt=%0d drop_cnt=%0d",
             frame_no, m_verdict_pass, m_verdict_reason, m_verdict_len, pass_cnt, drop_cnt);
  endtask

  initial begin
    rst = 1'b1;
    s_tdata = 8'h00;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    local_mac = GOOD_MAC;
    ethertype = 16'h0800;
    ip_protocol = 8'h11;
    ip_base = 32'h0A000100;
    ip_mask = 32'hFFFFFFFC;
    udp_dst_port = 16'h63DD;
    stats_clr = 1'b0;
    m_verdict_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_val("rst_tready", 64'(s_tready), 64'd1);
    check_val("rst_valid", 64'(m_verdict_valid), 64'd0);
    check_val("rst_pass", 64'(m_verdict_pass), 64'd0);
    check_val("rst_reason", 64'(m_verdict_reason), 64'd0);
    check_val("rst_len", 64'(m_verdict_len), 64'd0);
    check_val("rst_pass_cnt", 64'(pass_cnt), 64'd0);
    check_val("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // Basic pass and each failure reason in isolation.
    build_good();                 send(60, -1, -1); expect_verdict(1'b1, 3'd0, 60, 0, 1'b0);
    frame[33] = 8'h04;            send(60, -1, -1); expect_verdict(1'b0, 3'd5, 60, 0, 1'b0);
    build_good(); frame[33] = 8'h03; send(60, -1, -1); expect_verdict(1'b1, 3'd0, 60, 0, 1'b0);
    build(48'h0011_22334455, 16'h0800, 8'h45, 8'h11, 32'h0A000102, 16'h1111);
    send(60, -1, -1); expect_verdict(1'b0, 3'd1, 60, 0, 1'b0);
    build_good();                 send(20, -1, -1); expect_verdict(1'b0, 3'd7, 20, 0, 1'b0);
    build_good(); frame[13] = 8'hDD; send(60, -1, -1); expect_verdict(1'b0, 3'd2, 60, 0, 1'b0);
    build_good(); frame[14] = 8'h46; send(60, -1, -1); expect_verdict(1'b0, 3'd3, 60, 0, 1'b0);
    build_good(); frame[23] = 8'h06; send(60, -1, -1); expect_verdict(1'b0, 3'd4, 60, 0, 1'b0);
    build_good(); frame[37] = 8'hDE; send(60, -1, -1); expect_verdict(1'b0, 3'd6, 60, 0, 1'b0);
    build_good();                 send(38, -1, -1); expect_verdict(1'b1, 3'd0, 38, 0, 1'b0);
    build_good();                 send(70, -1, -1); expect_verdict(1'b1, 3'd0, LEN_MAX, 0, 1'b0);

    // Stalled consumer, then a back-to-back frame.
    m_verdict_ready = 1'b0;
    build_good(); send(60, -1, -1); expect_verdict(1'b1, 3'd0, 60, 10, 1'b0);
    send(60, -1, -1); expect_verdict(1'b1, 3'd0, 60, 0, 1'b0);

    // Port change mid-frame applies to the following frame only.
    build_good(); send(60, 20, -1); expect_verdict(1'b1, 3'd0, 60, 0, 1'b0);
    build(GOOD_MAC, 16'h0800, 8'h45, 8'h11, 32'h0A000102, 16'h1234);
    send(60, -1, -1); expect_verdict(1'b1, 3'd0, 60, 0, 1'b0);
    udp_dst_port = 16'h63DD;

    // Drive pass_cnt into saturation.
    build_good();
    for (int f = 0; f < 10; f++) begin
      send(40, -1, -1); expect_verdict(1'b1, 3'd0, 40, 0, 1'b0);
    end
    check_val("pass_cnt_sat", 64'(pass_cnt), 64'(CNT_MAX));

    // Clear coincident with a drop handshake.
    frame[0] = 8'h00; send(40, -1, -1); expect_verdict(1'b0, 3'd1, 40, 0, 1'b1);

    // Reset mid-frame, then a clean frame.
    build_good(); send(60, -1, 10);
    exp_pass = 0;
    exp_drop = 0;
    for (int k = 0; k < 5; k++) begin
      check_val("rst_mid_valid", 64'(m_verdict_valid), 64'd0);
      @(negedge clk);
    end
    check_val("rst_mid_pass_cnt", 64'(pass_cnt), 64'd0);
    send(60, -1, -1); expect_verdict(1'b1, 3'd0, 60, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
